// File: rtl/snn_timestep_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : snn_timestep_scheduler_if
// Description : Spike-input and MAC-broadcast bundle of the timestep scheduler.
// Revision    : 1.0  initial release
// ============================================================================
interface snn_timestep_scheduler_if #(
    parameter int ADDR_W = 12
);
    logic              spike_valid;
    logic [ADDR_W-1:0] spike_addr;
    logic              spike_ready;
    logic [ADDR_W-1:0] mac_addr;
    logic              mac_addr_valid;
    logic              mac_set;
    logic              mac_clear;
    logic              mac_done;

    modport master (
        output spike_valid, spike_addr, mac_done,
        input  spike_ready, mac_addr, mac_addr_valid, mac_set, mac_clear
    );

    modport slave (
        input  spike_valid, spike_addr, mac_done,
        output spike_ready, mac_addr, mac_addr_valid, mac_set, mac_clear
    );
endinterface
`default_nettype wire

// File: rtl/snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snn_timestep_scheduler
// Description : Buffers spike addresses, broadcasts them to the MAC array and
//               sequences set/clear strobes per timestep. Optional macro
//               SCHED_SPIKE_COUNT_EN adds per-timestep spike counters.
// Revision    : 1.0  initial release
// ============================================================================
module snn_timestep_scheduler #(
    parameter int ADDR_W      = 12,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_CYCLES   = 64,
    parameter int INIT_CYCLES = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    snn_timestep_scheduler_if.slave   bus,
    output logic [15:0]               ts_index,
    output logic                      busy
`ifdef SCHED_SPIKE_COUNT_EN
    ,
    output logic [15:0]               spike_count,
    output logic [15:0]               spike_count_last
`endif
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(TS_CYCLES + INIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TS_LAST   = c_CNT_W'(TS_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_INIT_LAST = c_CNT_W'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_RUN       = 3'd2,
        S_DRAIN     = 3'd3,
        S_CLEAR     = 3'd4,
        S_WAIT_DONE = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [ADDR_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 r_spike_ready;
    logic [ADDR_W-1:0]    r_mac_addr;
    logic                 r_mac_addr_valid;
    logic                 r_mac_set;
    logic                 r_mac_clear;
    logic                 r_busy;
    logic [15:0]          r_ts_index;

    logic                 w_empty;
    logic                 w_active;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_store;

    assign w_empty  = (r_count == '0);
    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_push   = bus.spike_valid & r_spike_ready;
    assign w_pop    = w_active & ~w_empty;
    // An empty FIFO forwards the incoming spike straight to the output register
    assign w_bypass = w_active & w_empty & w_push;
    assign w_store  = w_push & ~w_bypass;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next_state = S_INIT;
            S_INIT:      if (r_cnt == c_INIT_LAST) w_next_state = S_RUN;
            S_RUN:       if (r_cnt == c_TS_LAST) w_next_state = S_DRAIN;
            S_DRAIN:     if (w_empty) w_next_state = S_CLEAR;
            S_CLEAR:     w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.mac_done) w_next_state = stop ? S_IDLE : S_RUN;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (r_state == S_INIT || r_state == S_RUN)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_store)
            r_mem[r_wr_ptr] <= bus.spike_addr;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_store} - {{c_PTR_W{1'b0}}, w_pop};
        end
    end

    // Strobes are registered from the next state so they line up with it
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_spike_ready    <= 1'b0;
            r_mac_addr       <= '0;
            r_mac_addr_valid <= 1'b0;
            r_mac_set        <= 1'b0;
            r_mac_clear      <= 1'b0;
            r_busy           <= 1'b0;
            r_ts_index       <= '0;
        end else begin
            r_spike_ready <= (w_next_state == S_RUN);
            r_mac_set     <= (w_next_state == S_INIT);
            r_mac_clear   <= (w_next_state == S_CLEAR);
            r_busy        <= (w_next_state != S_IDLE);
            if (w_pop || w_bypass) begin
                r_mac_addr       <= w_pop ? r_mem[r_rd_ptr] : bus.spike_addr;
                r_mac_addr_valid <= 1'b1;
            end else begin
                r_mac_addr_valid <= 1'b0;
            end
            if (r_state == S_CLEAR)
                r_ts_index <= r_ts_index + 16'd1;
        end
    end

`ifdef SCHED_SPIKE_COUNT_EN
    logic [15:0] r_spike_count;
    logic [15:0] r_spike_count_last;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_spike_count      <= '0;
            r_spike_count_last <= '0;
        end else if (r_state == S_CLEAR) begin
            r_spike_count_last <= r_spike_count;
            r_spike_count      <= '0;
        end else if (w_push && (r_spike_count != 16'hFFFF)) begin
            r_spike_count <= r_spike_count + 16'd1;
        end
    end

    assign spike_count      = r_spike_count;
    assign spike_count_last = r_spike_count_last;
`endif

    assign bus.spike_ready    = r_spike_ready;
    assign bus.mac_addr       = r_mac_addr;
    assign bus.mac_addr_valid = r_mac_addr_valid;
    assign bus.mac_set        = r_mac_set;
    assign bus.mac_clear      = r_mac_clear;
    assign busy               = r_busy;
    assign ts_index           = r_ts_index;
endmodule
`default_nettype wire

// File: tb/tb_snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_timestep_scheduler
// Description : Directed vector table plus corner sequences for the scheduler.
// Revision    : 1.0  initial release
// ============================================================================
module tb_snn_timestep_scheduler;
    localparam int c_ADDR_W = 12;
    localparam int c_TS     = 8;
    localparam int c_INIT   = 4;
    localparam int c_DEPTH  = 8;

    logic        CLK   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [15:0] ts_index;
    logic        busy;
`ifdef SCHED_SPIKE_COUNT_EN
    logic [15:0] spike_count;
    logic [15:0] spike_count_last;
`endif

    snn_timestep_scheduler_if #(.ADDR_W(c_ADDR_W)) bus ();

    snn_timestep_scheduler #(
        .ADDR_W      (c_ADDR_W),
        .FIFO_DEPTH  (c_DEPTH),
        .TS_CYCLES   (c_TS),
        .INIT_CYCLES (c_INIT)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .bus      (bus),
        .ts_index (ts_index),
        .busy     (busy)
`ifdef SCHED_SPIKE_COUNT_EN
        ,
        .spike_count      (spike_count),
        .spike_count_last (spike_count_last)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        start, stop, valid;
        logic [11:0] addr;
        logic        done;
        logic        rdy, val;
        logic [11:0] maddr;
        logic        set, clr, bsy;
        logic [15:0] ts;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic st, input logic sp, input logic v, input logic [11:0] a,
                       input logic d, input logic r, input logic vl, input logic [11:0] ma,
                       input logic se, input logic cl, input logic bz, input logic [15:0] t);
        vec_t x;
        x.start = st; x.stop = sp; x.valid = v; x.addr = a; x.done = d;
        x.rdy = r; x.val = vl; x.maddr = ma; x.set = se; x.clr = cl; x.bsy = bz; x.ts = t;
        vecs.push_back(x);
    endtask

    function automatic logic [63:0] outs();
        return {31'd0, bus.spike_ready, bus.mac_addr_valid, bus.mac_addr,
                bus.mac_set, bus.mac_clear, busy, ts_index};
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t x);
        return {31'd0, x.rdy, x.val, x.maddr, x.set, x.clr, x.bsy, x.ts};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] nxt;
        logic [11:0] q[$];
        int          k, pushes, seen_clr, order_err, overlap;

        //   start stop vld addr   done | rdy val maddr  set clr bsy ts
        add(1,0,0,12'h000,0, 0,0,12'h000,0,0,0,16'd0);  // 0 IDLE
        add(1,0,0,12'h000,0, 0,0,12'h000,1,0,1,16'd0);  // 1 INIT (start ignored)
        add(0,0,0,12'h000,0, 0,0,12'h000,1,0,1,16'd0);
        add(0,0,0,12'h000,0, 0,0,12'h000,1,0,1,16'd0);
        add(0,0,0,12'h000,0, 0,0,12'h000,1,0,1,16'd0);  // 4 last INIT
        add(0,0,1,12'h000,0, 1,0,12'h000,0,0,1,16'd0);  // 5 RUN push 0
        add(0,0,1,12'h001,0, 1,1,12'h000,0,0,1,16'd0);
        add(0,0,1,12'h002,0, 1,1,12'h001,0,0,1,16'd0);
        add(0,0,0,12'h000,0, 1,1,12'h002,0,0,1,16'd0);
        add(0,0,0,12'h000,1, 1,0,12'h002,0,0,1,16'd0);  // 9 mac_done ignored
        add(0,0,0,12'h000,0, 1,0,12'h002,0,0,1,16'd0);
        add(0,0,0,12'h000,0, 1,0,12'h002,0,0,1,16'd0);
        add(0,0,1,12'h0AB,0, 1,0,12'h002,0,0,1,16'd0);  // 12 last RUN push
        add(0,0,0,12'h000,0, 0,1,12'h0AB,0,0,1,16'd0);  // 13 DRAIN dispatch
        add(0,0,0,12'h000,0, 0,0,12'h0AB,0,1,1,16'd0);  // 14 CLEAR
        add(0,0,0,12'h000,0, 0,0,12'h0AB,0,0,1,16'd1);  // 15 WAIT_DONE
        add(0,0,0,12'h000,0, 0,0,12'h0AB,0,0,1,16'd1);
        add(0,0,0,12'h000,1, 0,0,12'h0AB,0,0,1,16'd1);  // 17 done, no stop
        add(0,0,0,12'h000,0, 1,0,12'h0AB,0,0,1,16'd1);  // 18 RUN
        add(0,1,0,12'h000,0, 1,0,12'h0AB,0,0,1,16'd1);
        add(0,1,1,12'h100,0, 1,0,12'h0AB,0,0,1,16'd1);
        add(0,1,1,12'hFFF,0, 1,1,12'h100,0,0,1,16'd1);
        add(0,1,0,12'h000,0, 1,1,12'hFFF,0,0,1,16'd1);
        add(0,1,0,12'h000,0, 1,0,12'hFFF,0,0,1,16'd1);
        add(0,1,0,12'h000,0, 1,0,12'hFFF,0,0,1,16'd1);
        add(0,1,0,12'h000,0, 1,0,12'hFFF,0,0,1,16'd1);  // 25 last RUN
        add(0,1,0,12'h000,0, 0,0,12'hFFF,0,0,1,16'd1);  // 26 DRAIN
        add(0,1,0,12'h000,1, 0,0,12'hFFF,0,1,1,16'd1);  // 27 CLEAR
        add(0,1,0,12'h000,1, 0,0,12'hFFF,0,0,1,16'd2);  // 28 WAIT_DONE
        add(0,0,0,12'h000,0, 0,0,12'hFFF,0,0,0,16'd2);  // 29 IDLE

        bus.spike_valid = 1'b0;
        bus.spike_addr  = '0;
        bus.mac_done    = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_state", outs(), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("vec%0d", i), outs(), pack_exp(vecs[i]));
`ifdef SCHED_SPIKE_COUNT_EN
            if (i == 15) check("cnt_last_ts1", {spike_count_last, spike_count}, {16'd4, 16'd0});
            if (i == 22) check("cnt_run_ts2", spike_count, 16'd2);
            if (i == 29) check("cnt_last_ts2", spike_count_last, 16'd2);
`endif
            start           = vecs[i].start;
            stop            = vecs[i].stop;
            bus.spike_valid = vecs[i].valid;
            bus.spike_addr  = vecs[i].addr;
            bus.mac_done    = vecs[i].done;
            @(negedge CLK);
        end

        // Continuous spike stream with mac_done held low
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        k = 0;
        while (!bus.spike_ready && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("a_ready_seen", bus.spike_ready, 1);
        nxt = 12'h200; pushes = 0; seen_clr = 0; order_err = 0; overlap = 0;
        for (int c = 0; c < 40 && seen_clr == 0; c++) begin
            if (bus.mac_addr_valid) begin
                if (q.size() == 0 || bus.mac_addr !== q[0]) order_err++;
                else void'(q.pop_front());
            end
            if (bus.mac_clear) begin
                seen_clr = 1;
                if (bus.mac_addr_valid) overlap++;
            end
            bus.spike_valid = 1'b1;
            bus.spike_addr  = nxt;
            if (bus.spike_ready) begin
                q.push_back(nxt);
                pushes++;
                nxt++;
            end
            @(negedge CLK);
        end
        bus.spike_valid = 1'b0;
        check("a_clear_seen", seen_clr, 1);
        check("a_push_count", pushes, c_TS);
        check("a_all_dispatched", q.size(), 0);
        check("a_order", order_err, 0);
        check("a_clear_overlap", overlap, 0);
        repeat (5) @(negedge CLK);
        check("a_wait_done_hold", {bus.mac_clear, bus.spike_ready, busy, ts_index}, {1'b0, 1'b0, 1'b1, 16'd3});

        // Reset from WAIT_DONE, then asynchronous reset mid-RUN
        reset = 1'b1;
        @(negedge CLK);
        check("b_reset_wait", outs(), 64'd0);
        reset = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        k = 0;
        while (!bus.spike_ready && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("b_ready_seen", bus.spike_ready, 1);
        for (int j = 0; j < 3; j++) begin
            bus.spike_valid = 1'b1;
            bus.spike_addr  = 12'h300 + 12'(j);
            @(negedge CLK);
        end
        bus.spike_valid = 1'b0;
        check("b_dispatch_before_reset", {bus.mac_addr_valid, bus.mac_addr}, {1'b1, 12'h302});
        #2 reset = 1'b1;
        #1 check("b_async_reset", outs(), 64'd0);
        @(negedge CLK);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            check($sformatf("b_post_reset%0d", j), outs(), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
